// File: rtl/crc32_frame_ctrl.sv
// Framed CRC-32 sequencer: one byte per beat, MSB-first step, with init,
// in/out reflection and final XOR. Generates an FCS or checks the residue.
module crc32_frame_ctrl #(
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT_IN  = 1'b1,
    parameter bit          REFLECT_OUT = 1'b1,
    parameter logic [31:0] RESIDUE     = 32'hC704DD7B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_crc,
    output logic        res_ok,
    output logic        err
);

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] crc_reg, crc_nxt;
    logic [31:0] crc_base, step_out, out_val;
    logic [7:0]  data_in;
    logic        beat, latch, err_set;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        rev8 = {<<{v}};
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        rev32 = {<<{v}};
    endfunction

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {d, 24'h000000};
        for (int unsigned i = 0; i < 8; i++)
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        crc_step = r;
    endfunction

    assign in_ready  = (state != DONE);
    assign res_valid = (state == DONE);
    assign beat      = in_valid && in_ready;

    // An SOF byte always starts from INIT, which also covers the mid-frame restart.
    assign crc_base = in_sof ? INIT : crc_reg;
    assign data_in  = REFLECT_IN ? rev8(in_data) : in_data;
    assign step_out = crc_step(crc_base, data_in);
    assign out_val  = (REFLECT_OUT ? rev32(step_out) : step_out) ^ XOR_OUT;

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc_reg;
        latch     = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (!in_sof) begin
                        err_set = 1'b1;
                    end else if (in_eof) begin
                        latch     = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        crc_nxt   = step_out;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (beat) begin
                    err_set = in_sof;
                    if (in_eof) begin
                        latch     = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        crc_nxt = step_out;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    crc_nxt   = INIT;
                    state_nxt = IDLE;
                end
            end
            default: begin
                crc_nxt   = INIT;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            crc_reg <= INIT;
            res_crc <= '0;
            res_ok  <= 1'b0;
            err     <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            crc_reg <= INIT;
            res_crc <= '0;
            res_ok  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            crc_reg <= crc_nxt;
            err     <= err | err_set;
            if (latch) begin
                res_crc <= out_val;
                res_ok  <= (step_out == RESIDUE);
            end
        end
    end

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Scoreboard bench for crc32_frame_ctrl: stimulus pushes expected results,
// a monitor pops and compares on each result handshake.
module tb_crc32_frame_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        in_eof;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_crc;
    logic        res_ok;
    logic        err;

    typedef struct {
        logic [31:0] crc;
        logic        ok;
        logic        chk_crc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  fbuf[0:15];
    int          n_checks = 0;
    int          n_fail   = 0;

    crc32_frame_ctrl #(
        .INIT(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF),
        .REFLECT_IN(1'b1),
        .REFLECT_OUT(1'b1),
        .RESIDUE(32'hC704DD7B)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_sof(in_sof),
        .in_eof(in_eof),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_crc(res_crc),
        .res_ok(res_ok),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is consumed when valid and ready are both seen.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got crc %h ok %0d expected no result", res_crc, res_ok);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_crc) chk("res_crc", res_crc, e.crc);
                chk("res_ok", {31'b0, res_ok}, {31'b0, e.ok});
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        in_eof   = e;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [31:0] crc, input logic ok,
                              input logic chk_crc, input logic lat);
        exp_t e;
        e.crc     = crc;
        e.ok      = ok;
        e.chk_crc = chk_crc;
        sb.push_back(e);
        for (int i = 0; i < len; i++)
            send_byte(fbuf[i], (i == 0), (i == len - 1));
        if (lat) begin
            @(negedge clk);
            chk("latency_res_valid", {31'b0, res_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_check();
        for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sof    = 1'b0;
        in_eof    = 1'b0;
        res_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_err",       {31'b0, err},       32'd0);
        chk("rst_res_crc",   res_crc,            32'h0);
        chk("rst_res_ok",    {31'b0, res_ok},    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Check string
        load_check();
        send_frame(9, 32'hCBF43926, 1'b0, 1'b1, 1'b1);

        // Frame with its FCS appended (LSB-first), then corrupted
        load_check();
        fbuf[9]  = 8'h26;
        fbuf[10] = 8'h39;
        fbuf[11] = 8'hF4;
        fbuf[12] = 8'hCB;
        send_frame(13, 32'h2144DF1C, 1'b1, 1'b1, 1'b1);
        fbuf[2] = 8'h00;
        send_frame(13, 32'h0, 1'b0, 1'b0, 1'b1);

        // Single zero byte
        fbuf[0] = 8'h00;
        send_frame(1, 32'hD202EF8D, 1'b0, 1'b1, 1'b1);

        // Backpressure: result held, second frame stalls until the handshake
        res_ready = 1'b0;
        load_check();
        send_frame(9, 32'hCBF43926, 1'b0, 1'b1, 1'b1);
        fbuf[0] = 8'h00;
        fork
            send_frame(1, 32'hD202EF8D, 1'b0, 1'b1, 1'b0);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
                    chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
                    chk("stall_res_crc",   res_crc,            32'hCBF43926);
                end
                @(posedge clk);
                #1 res_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Stray byte in IDLE
        send_byte(8'h31, 1'b0, 1'b0);
        @(negedge clk);
        chk("stray_err",       {31'b0, err},       32'd1);
        chk("stray_res_valid", {31'b0, res_valid}, 32'd0);
        chk("stray_in_ready",  {31'b0, in_ready},  32'd1);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;

        // Second SOF mid-frame restarts the frame
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        load_check();
        send_frame(9, 32'hCBF43926, 1'b0, 1'b1, 1'b1);
        chk("restart_err", {31'b0, err}, 32'd1);

        // Asynchronous reset mid-frame, mid-cycle
        send_byte(8'h31, 1'b1, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("arst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("arst_err",       {31'b0, err},       32'd0);
        chk("arst_res_crc",   res_crc,            32'h0);
        chk("arst_res_ok",    {31'b0, res_ok},    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // clr mid-frame, colliding with an SOF+EOF beat that must be refused
        send_byte(8'h31, 1'b0, 1'b0);
        send_byte(8'h31, 1'b1, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        in_sof   = 1'b1;
        in_eof   = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        @(negedge clk);
        chk("clrmid_err",       {31'b0, err},       32'd0);
        chk("clrmid_res_valid", {31'b0, res_valid}, 32'd0);
        chk("clrmid_in_ready",  {31'b0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        load_check();
        send_frame(9, 32'hCBF43926, 1'b0, 1'b1, 1'b1);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
